scoreboard: RTL

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/scoreboard_pkg.sv | 30 +++
 rtl/scoreboard_if.sv | 55 +++++
 rtl/scoreboard_warp_table.sv | 96 +++++++++
 rtl/scoreboard.sv | 107 ++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared GPGPU parameters and the scoreboard entry record.
package GPGPUParam;

    localparam int NUM_WARP_LOG    = 2;
    localparam int NUM_WARP        = 1 << NUM_WARP_LOG;
    localparam int SIZE_REGFILE    = 6;
    localparam int SIZE_REGFILE_BR = 5;
    localparam int SB_ENTRIES      = 4;
    localparam int SB_ENTRIES_LOG  = $clog2(SB_ENTRIES);

    typedef logic [SIZE_REGFILE-1:0]    reg_t;
    typedef logic [SIZE_REGFILE_BR-1:0] reg_br_t;

    // One pending-write slot: a valid flag plus the truncated destination register.
    typedef struct packed {
        logic    valid;
        reg_br_t regn;
    } sb_entry_t;

    // Register 0 is decided on the full register value, never on the truncated one.
    function automatic logic reg_nonzero(input reg_t r);
        return r != '0;
    endfunction

    // All scoreboard matching is done on the low SIZE_REGFILE_BR bits.
    function automatic reg_br_t reg_br(input reg_t r);
        return r[SIZE_REGFILE_BR-1:0];
    endfunction

endpackage

// File: rtl/scoreboard_if.sv
// Issue/writeback/status bundle between the issue stage and the scoreboard.
//
// Handshake: an instruction is accepted on a rising edge exactly when
// issueValid_i && issueReady_o are both high in that cycle. issueReady_o is a
// pure function of the current issue fields, the table state and stall_i; it
// never depends on issueValid_i, so the issuer may hold or change its request
// freely while not ready. Writebacks have no ready: a writeback is consumed at
// every edge where its valid is high and stall_i is low.
interface scoreboard_if #(
    parameter int SB_ENTRIES = GPGPUParam::SB_ENTRIES
) ();
    import GPGPUParam::*;

    localparam int CNT_W = $clog2(SB_ENTRIES) + 1;

    logic                    stall_i;
    logic                    issueValid_i;
    logic [NUM_WARP_LOG-1:0] issueWarp_i;
    logic                    issueSRValid_i;
    logic [SIZE_REGFILE-1:0] issueSrc1_i;
    logic [SIZE_REGFILE-1:0] issueSrc2_i;
    logic [SIZE_REGFILE-1:0] issueSrc3_i;
    logic                    issueDestValid_i;
    logic [SIZE_REGFILE-1:0] issueDestReg_i;
    logic                    intuWbValid_i;
    logic [NUM_WARP_LOG-1:0] intuWbWarp_i;
    logic [SIZE_REGFILE-1:0] intuWbReg_i;
    logic                    loadWbValid_i;
    logic [NUM_WARP_LOG-1:0] loadWbWarp_i;
    logic [SIZE_REGFILE-1:0] loadWbReg_i;
    logic                    issueReady_o;
    logic                    hazard_o;
    logic                    full_o;
    logic [CNT_W-1:0]        pendingCount_o;
    logic                    spuriousWb_o;

    modport master (
        output stall_i, issueValid_i, issueWarp_i, issueSRValid_i,
               issueSrc1_i, issueSrc2_i, issueSrc3_i,
               issueDestValid_i, issueDestReg_i,
               intuWbValid_i, intuWbWarp_i, intuWbReg_i,
               loadWbValid_i, loadWbWarp_i, loadWbReg_i,
        input  issueReady_o, hazard_o, full_o, pendingCount_o, spuriousWb_o
    );

    modport slave (
        input  stall_i, issueValid_i, issueWarp_i, issueSRValid_i,
               issueSrc1_i, issueSrc2_i, issueSrc3_i,
               issueDestValid_i, issueDestReg_i,
               intuWbValid_i, intuWbWarp_i, intuWbReg_i,
               loadWbValid_i, loadWbWarp_i, loadWbReg_i,
        output issueReady_o, hazard_o, full_o, pendingCount_o, spuriousWb_o
    );

endinterface

// File: rtl/scoreboard_warp_table.sv
// One warp's pending-write table: hazard match, lowest-free allocation and
// dual-port release. All decisions look at pre-edge state only.
module sb_warp_table
    import GPGPUParam::*;
#(
    parameter int SB_ENTRIES = GPGPUParam::SB_ENTRIES,
    parameter int CNT_W      = $clog2(SB_ENTRIES) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    // query: src1, src2, src3, dest; enable already folds in reg0 and SR rules
    input  logic [3:0]                            q_en_i,
    input  logic [3:0][SIZE_REGFILE_BR-1:0]       q_reg_i,
    input  logic                                  alloc_en_i,
    input  reg_br_t                               alloc_reg_i,
    input  logic                                  intu_rel_en_i,
    input  reg_br_t                               intu_reg_i,
    input  logic                                  load_rel_en_i,
    input  reg_br_t                               load_reg_i,
    output logic                                  hazard_o,
    output logic                                  all_valid_o,
    output logic [CNT_W-1:0]                      count_o,
    output logic                                  intu_hit_o,
    output logic                                  load_hit_o
);

    sb_entry_t              entries_q [SB_ENTRIES];
    sb_entry_t              entries_d [SB_ENTRIES];
    logic [SB_ENTRIES-1:0]  alloc_sel;
    logic [SB_ENTRIES-1:0]  intu_match;
    logic [SB_ENTRIES-1:0]  load_match;
    logic                   free_found;

    // Match, occupancy and lowest-free selection from current entries.
    always_comb begin
        hazard_o    = 1'b0;
        all_valid_o = 1'b1;
        count_o     = '0;
        intu_hit_o  = 1'b0;
        load_hit_o  = 1'b0;
        alloc_sel   = '0;
        intu_match  = '0;
        load_match  = '0;
        free_found  = 1'b0;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            if (entries_q[i].valid) begin
                for (int q = 0; q < 4; q++) begin
                    if (q_en_i[q] && (entries_q[i].regn == q_reg_i[q])) begin
                        hazard_o = 1'b1;
                    end
                end
                intu_match[i] = (entries_q[i].regn == intu_reg_i);
                load_match[i] = (entries_q[i].regn == load_reg_i);
                count_o       = count_o + CNT_W'(1);
            end else begin
                all_valid_o = 1'b0;
                if (!free_found) begin
                    alloc_sel[i] = 1'b1;
                    free_found   = 1'b1;
                end
            end
        end
        intu_hit_o = |intu_match;
        load_hit_o = |load_match;
    end

    // Next state: both releases may clear the same slot; allocation only
    // lands on a slot that was free before the edge, so it never collides.
    always_comb begin
        for (int i = 0; i < SB_ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            if (intu_rel_en_i && intu_match[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (load_rel_en_i && load_match[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (alloc_en_i && alloc_sel[i]) begin
                entries_d[i].valid = 1'b1;
                entries_d[i].regn  = alloc_reg_i;
            end
        end
    end

    // Entry register with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_ENTRIES; i++) begin
            if (reset) begin
                entries_q[i] <= '0;
            end else begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: rtl/scoreboard.sv
// Per-warp register scoreboard: blocks issue on RAW/WAW hazards or a full
// table, tracks pending writes and retires them on INTU/load writeback.
module scoreboard
    import GPGPUParam::*;
#(
    parameter int SB_ENTRIES = GPGPUParam::SB_ENTRIES
) (
    input  logic         clk,
    input  logic         reset,
    scoreboard_if.slave  sb
);

    localparam int CNT_W = $clog2(SB_ENTRIES) + 1;

    logic [3:0]                      q_en;
    logic [3:0][SIZE_REGFILE_BR-1:0] q_reg;
    logic [NUM_WARP-1:0]             haz_vec;
    logic [NUM_WARP-1:0]             allv_vec;
    logic [NUM_WARP-1:0]             intu_hit_vec;
    logic [NUM_WARP-1:0]             load_hit_vec;
    logic [NUM_WARP-1:0]             alloc_en_vec;
    logic [NUM_WARP-1:0]             intu_rel_vec;
    logic [NUM_WARP-1:0]             load_rel_vec;
    logic [CNT_W-1:0]                cnt_vec [NUM_WARP];
    logic                            dest_live;
    logic                            hazard;
    logic                            full;
    logic                            ready;
    logic                            alloc_fire;
    logic                            intu_fire;
    logic                            load_fire;
    logic                            spurious_d;
    logic                            spurious_q;

    // Operands that can create a hazard; register 0 and SR sources never do.
    always_comb begin
        dest_live = sb.issueDestValid_i && reg_nonzero(sb.issueDestReg_i);
        q_en[0]   = !sb.issueSRValid_i && reg_nonzero(sb.issueSrc1_i);
        q_en[1]   = reg_nonzero(sb.issueSrc2_i);
        q_en[2]   = reg_nonzero(sb.issueSrc3_i);
        q_en[3]   = dest_live;
        q_reg[0]  = reg_br(sb.issueSrc1_i);
        q_reg[1]  = reg_br(sb.issueSrc2_i);
        q_reg[2]  = reg_br(sb.issueSrc3_i);
        q_reg[3]  = reg_br(sb.issueDestReg_i);
    end

    // Every warp sees the same query; only the addressed warp's result is used.
    for (genvar w = 0; w < NUM_WARP; w++) begin : g_warp
        sb_warp_table #(
            .SB_ENTRIES (SB_ENTRIES),
            .CNT_W      (CNT_W)
        ) u_table (
            .clk           (clk),
            .reset         (reset),
            .q_en_i        (q_en),
            .q_reg_i       (q_reg),
            .alloc_en_i    (alloc_en_vec[w]),
            .alloc_reg_i   (reg_br(sb.issueDestReg_i)),
            .intu_rel_en_i (intu_rel_vec[w]),
            .intu_reg_i    (reg_br(sb.intuWbReg_i)),
            .load_rel_en_i (load_rel_vec[w]),
            .load_reg_i    (reg_br(sb.loadWbReg_i)),
            .hazard_o      (haz_vec[w]),
            .all_valid_o   (allv_vec[w]),
            .count_o       (cnt_vec[w]),
            .intu_hit_o    (intu_hit_vec[w]),
            .load_hit_o    (load_hit_vec[w])
        );
    end

    // Issue acceptance, per-warp allocate/release steering, spurious detect.
    always_comb begin
        hazard     = haz_vec[sb.issueWarp_i];
        full       = allv_vec[sb.issueWarp_i] && dest_live;
        ready      = !hazard && !full && !sb.stall_i;
        alloc_fire = sb.issueValid_i && ready && dest_live;
        intu_fire  = sb.intuWbValid_i && !sb.stall_i && reg_nonzero(sb.intuWbReg_i);
        load_fire  = sb.loadWbValid_i && !sb.stall_i && reg_nonzero(sb.loadWbReg_i);
        for (int w = 0; w < NUM_WARP; w++) begin
            alloc_en_vec[w] = alloc_fire && (sb.issueWarp_i == NUM_WARP_LOG'(w));
            intu_rel_vec[w] = intu_fire && (sb.intuWbWarp_i == NUM_WARP_LOG'(w));
            load_rel_vec[w] = load_fire && (sb.loadWbWarp_i == NUM_WARP_LOG'(w));
        end
        spurious_d = (intu_fire && !intu_hit_vec[sb.intuWbWarp_i])
                  || (load_fire && !load_hit_vec[sb.loadWbWarp_i]);
    end

    // One-cycle registered pulse for a writeback that found nothing to retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= spurious_d;
        end
    end

    // Drive the status outputs.
    always_comb begin
        sb.hazard_o       = hazard;
        sb.full_o         = full;
        sb.issueReady_o   = ready;
        sb.pendingCount_o = cnt_vec[sb.issueWarp_i];
        sb.spuriousWb_o   = spurious_q;
    end

endmodule
